// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes (also used by the ALU control decoder),
// execute-stage state encoding and default datapath width.
package alu_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  localparam logic [3:0] ADD  = 4'b1111;
  localparam logic [3:0] ADDR = 4'b0011;
  localparam logic [3:0] SUB  = 4'b1110;
  localparam logic [3:0] CMP  = 4'b0100;
  localparam logic [3:0] AND  = 4'b1101;
  localparam logic [3:0] OR   = 4'b1100;
  localparam logic [3:0] MUL  = 4'b0001;
  localparam logic [3:0] DIV  = 4'b0010;
  localparam logic [3:0] SLL  = 4'b1010;
  localparam logic [3:0] SLR  = 4'b1011;
  localparam logic [3:0] ROL  = 4'b1000;
  localparam logic [3:0] ROR  = 4'b1001;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative signed multiply / divide on magnitudes, one bit per cycle.
// go loads operands; fin is high during the final iteration, after which lo/hi are sign-fixed.
module alu_muldiv_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   hi_q, lo_q, mag_q, hi_d, lo_d;
  logic [CW-1:0]      cnt_q;
  logic               run_q, div_q, neg_lo_q, neg_hi_q;
  logic [WIDTH:0]     acc, rem;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Multiply: {hi,lo} is the shift-add product register, lo starts as the multiplier.
  // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
  always_comb begin
    acc  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    rem  = {hi_q, lo_q[WIDTH-1]};
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_q) begin
      lo_d = {lo_q[WIDTH-2:0], 1'b0};
      if (rem >= {1'b0, mag_q}) begin
        rem     = rem - {1'b0, mag_q};
        lo_d[0] = 1'b1;
      end
      hi_d = rem[WIDTH-1:0];
    end else begin
      {hi_d, lo_d} = {acc, lo_q[WIDTH-1:1]};
    end
  end

  assign fin  = run_q && (cnt_q == CW'(WIDTH - 1));
  assign prod = neg_lo_q ? -{hi_q, lo_q} : {hi_q, lo_q};

  always_comb begin
    if (div_q) begin
      lo = neg_lo_q ? -lo_q : lo_q;
      hi = neg_hi_q ? -hi_q : hi_q;
    end else begin
      {hi, lo} = prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      mag_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (go) begin
      hi_q     <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
      div_q    <= is_div;
      neg_lo_q <= a[WIDTH-1] ^ b[WIDTH-1];
      // Remainder follows the dividend's sign.
      neg_hi_q <= is_div & a[WIDTH-1];
      lo_q     <= is_div ? mag(a) : mag(b);
      mag_q    <= is_div ? mag(b) : mag(a);
    end else if (run_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CW'(1);
      if (fin) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus iterative signed mul/div
// behind a start/busy/done handshake. All outputs are registered and update at done.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             lt,
  output logic             div0
);

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

  alu_state_e         state_q;
  logic [WIDTH-1:0]   sc_res, sc_hi, sum, diff, core_lo, core_hi;
  logic               sc_ovf, sc_lt, sc_div0, iter_op, accept, core_fin;
  logic               div_op_q, div_ovf_q;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] rot_l, rot_r;

  assign sh     = b[SHW-1:0];
  assign sum    = a + b;
  assign diff   = a - b;
  assign rot_l  = {a, a} << sh;
  assign rot_r  = {a, a} >> sh;
  assign accept = (state_q == StIdle) && start;
  // Divide by zero short-circuits to the single-cycle path.
  assign iter_op = (alu_ctrl == MUL) || ((alu_ctrl == DIV) && (b != '0));

  always_comb begin
    sc_res  = '0;
    sc_hi   = '0;
    sc_ovf  = 1'b0;
    sc_lt   = 1'b0;
    sc_div0 = 1'b0;
    case (alu_ctrl)
      ADD, ADDR: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      SUB, CMP: begin
        sc_res = diff;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        sc_lt  = diff[WIDTH-1] ^ sc_ovf;
      end
      AND: sc_res = a & b;
      OR:  sc_res = a | b;
      SLL: sc_res = a << sh;
      SLR: sc_res = a >> sh;
      ROL: sc_res = rot_l[2*WIDTH-1:WIDTH];
      ROR: sc_res = rot_r[WIDTH-1:0];
      DIV: begin
        sc_res  = '1;
        sc_hi   = a;
        sc_div0 = 1'b1;
      end
      default: ;
    endcase
  end

  alu_muldiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .go    (accept && iter_op),
    .is_div(alu_ctrl == DIV),
    .a     (a),
    .b     (b),
    .fin   (core_fin),
    .lo    (core_lo),
    .hi    (core_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      lt        <= 1'b0;
      div0      <= 1'b0;
      div_op_q  <= 1'b0;
      div_ovf_q <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && iter_op) begin
            state_q   <= (alu_ctrl == MUL) ? StMul : StDiv;
            busy      <= 1'b1;
            div_op_q  <= (alu_ctrl == DIV);
            div_ovf_q <= (a == MinVal) && (b == '1);
          end else if (start) begin
            state_q   <= StDone;
            done      <= 1'b1;
            result    <= sc_res;
            result_hi <= sc_hi;
            zero      <= (sc_res == '0);
            neg       <= sc_res[WIDTH-1];
            ovf       <= sc_ovf;
            lt        <= sc_lt;
            div0      <= sc_div0;
          end
        end
        StMul, StDiv: begin
          if (core_fin) state_q <= StFix;
        end
        StFix: begin
          state_q   <= StDone;
          busy      <= 1'b0;
          done      <= 1'b1;
          result    <= core_lo;
          result_hi <= core_hi;
          zero      <= (core_lo == '0);
          neg       <= core_lo[WIDTH-1];
          ovf       <= div_op_q ? div_ovf_q : (core_hi != {WIDTH{core_lo[WIDTH-1]}});
          lt        <= 1'b0;
          div0      <= 1'b0;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus random ops checked against an
// arithmetic reference model.
module tb_alu_exec;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] a, b;
  logic         busy, done, zero, neg, ovf, lt, div0;
  logic [W-1:0] result, result_hi;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic        zero, neg, ovf, lt, div0;
    int          lat;
  } exp_t;

  always #5 clk = ~clk;

  alu_exec #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .result_hi(result_hi),
    .zero     (zero),
    .neg      (neg),
    .ovf      (ovf),
    .lt       (lt),
    .div0     (div0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rot(input logic [15:0] x, input int n, input bit left);
    logic [15:0] v;
    v = x;
    for (int i = 0; i < n; i++) v = left ? {v[14:0], v[15]} : {v[0], v[15:1]};
    return v;
  endfunction

  function automatic exp_t model(input logic [3:0] c, input logic [15:0] x, input logic [15:0] y);
    exp_t        e;
    int          sx, sy, r, sh;
    logic [31:0] p;
    sx    = $signed(x);
    sy    = $signed(y);
    sh    = int'(y[3:0]);
    e     = '0;
    e.lat = 1;
    case (c)
      4'b1111, 4'b0011: begin
        r     = sx + sy;
        e.res = 16'(r);
        e.ovf = (r > 32767) || (r < -32768);
      end
      4'b1110, 4'b0100: begin
        r     = sx - sy;
        e.res = 16'(r);
        e.ovf = (r > 32767) || (r < -32768);
        e.lt  = (sx < sy);
      end
      4'b1101: e.res = x & y;
      4'b1100: e.res = x | y;
      4'b0001: begin
        r     = sx * sy;
        p     = r;
        e.res = p[15:0];
        e.hi  = p[31:16];
        e.ovf = (r > 32767) || (r < -32768);
        e.lat = W + 2;
      end
      4'b0010: begin
        if (y == 16'h0000) begin
          e.res  = 16'hFFFF;
          e.hi   = x;
          e.div0 = 1'b1;
        end else if (sx == -32768 && sy == -1) begin
          e.res = 16'h8000;
          e.ovf = 1'b1;
          e.lat = W + 2;
        end else begin
          e.res = 16'(sx / sy);
          e.hi  = 16'(sx % sy);
          e.lat = W + 2;
        end
      end
      4'b1010: e.res = x << sh;
      4'b1011: e.res = x >> sh;
      4'b1000: e.res = rot(x, sh, 1'b1);
      4'b1001: e.res = rot(x, sh, 1'b0);
      default: e.res = 16'h0000;
    endcase
    e.zero = (e.res == 16'h0000);
    e.neg  = e.res[15];
    return e;
  endfunction

  // Issue one op, wait (bounded) for done, then compare everything against the model.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [15:0] x,
                        input logic [15:0] y);
    exp_t e;
    int   cyc, bcnt;
    e        = model(c, x, y);
    alu_ctrl = c;
    a        = x;
    b        = y;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    alu_ctrl = 4'($urandom);
    cyc      = 1;
    bcnt     = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
    if (busy) bcnt++;
    check({tag, " latency"}, 32'(cyc), 32'(e.lat));
    check({tag, " busy cycles"}, 32'(bcnt), 32'(e.lat - 1));
    check({tag, " result"}, 32'(result), 32'(e.res));
    check({tag, " result_hi"}, 32'(result_hi), 32'(e.hi));
    check({tag, " zero"}, 32'(zero), 32'(e.zero));
    check({tag, " neg"}, 32'(neg), 32'(e.neg));
    check({tag, " ovf"}, 32'(ovf), 32'(e.ovf));
    check({tag, " lt"}, 32'(lt), 32'(e.lt));
    check({tag, " div0"}, 32'(div0), 32'(e.div0));
    tick();
    check({tag, " done pulse width"}, 32'(done), 32'd0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h0000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    exp_t e;
    rst      = 1'b1;
    start    = 1'b0;
    alu_ctrl = 4'h0;
    a        = '0;
    b        = '0;
    repeat (3) tick();
    check("reset outputs", {result, result_hi}, 32'd0);
    check("reset flags", 32'({busy, done, zero, neg, ovf, lt, div0}), 32'd0);
    rst = 1'b0;

    run_op("add ovf", 4'b1111, 16'h7FFF, 16'h0001);
    run_op("mul 7x-3", 4'b0001, 16'h0007, 16'hFFFD);
    run_op("mul 256x256", 4'b0001, 16'h0100, 16'h0100);
    run_op("div -7/2", 4'b0010, 16'hFFF9, 16'h0002);
    run_op("div min/-1", 4'b0010, 16'h8000, 16'hFFFF);
    run_op("div by zero", 4'b0010, 16'h0005, 16'h0000);
    run_op("ror", 4'b1001, 16'h0001, 16'h0001);
    run_op("rol", 4'b1000, 16'h8001, 16'h0004);
    run_op("slr", 4'b1011, 16'h8000, 16'h000F);
    run_op("sll amt0", 4'b1010, 16'h1234, 16'h0010);
    run_op("cmp 3<5", 4'b0100, 16'h0003, 16'h0005);
    run_op("unknown", 4'b0000, 16'h1234, 16'h5678);

    // A start during a busy mul and a start in the DONE cycle are both dropped.
    e        = model(4'b0001, 16'h0123, 16'hFF00);
    alu_ctrl = 4'b0001;
    a        = 16'h0123;
    b        = 16'hFF00;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    alu_ctrl = 4'b1111;
    a        = 16'h0001;
    b        = 16'h0001;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) tick();
    check("busy-start done", 32'(done), 32'd1);
    check("busy-start result", {result_hi, result}, {e.hi, e.res});
    alu_ctrl = 4'b1111;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("done-cycle start ignored", 32'({busy, done}), 32'd0);
    tick();
    check("done-cycle start no done", 32'(done), 32'd0);
    check("done-cycle start result", {result_hi, result}, {e.hi, e.res});

    // Reset in the middle of a divide aborts it.
    alu_ctrl = 4'b0010;
    a        = 16'h7000;
    b        = 16'h0003;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-div reset outputs", {result, result_hi}, 32'd0);
    check("mid-div reset flags", 32'({busy, done, zero, neg, ovf, lt, div0}), 32'd0);
    run_op("post-reset mul", 4'b0001, 16'hFF85, 16'h0031);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  c;
      logic [15:0] x, y;
      c = 4'($urandom);
      x = pick();
      y = pick();
      run_op($sformatf("rnd%0d op%b", i, c), c, x, y);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
